// File: rtl/if_fetch.sv
// Instruction fetch: single-outstanding memory request FSM feeding a prefetch FIFO.
// Define IF_FETCH_STATS_EN to add the stat_fetch_o / stat_bubble_o counters.
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        hd_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_valid_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
`ifdef IF_FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetch_o,
    output logic [31:0] stat_bubble_o
`endif
);

    localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam logic [31:0] BUBBLE = 32'hFC00_0000;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        addr_q, addr_d;
    logic               req_q, req_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        buf_data_q [BUF_DEPTH];
    logic [31:0]        buf_addr_q [BUF_DEPTH];
    logic               push, pop, empty;

    assign empty = (cnt_q == '0);

    // Request FSM and FIFO pointer update; redirect overrides everything else.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        push    = 1'b0;
        pop     = 1'b0;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        if (redirect_i) begin
            pc_d    = redirect_addr_i & 32'hFFFF_FFFC;
            state_d = (state_q != S_IDLE && !imem_valid_i) ? S_DROP : S_IDLE;
            head_d  = '0;
            tail_d  = '0;
            cnt_d   = '0;
        end else begin
            pop = !hd_i && !empty;
            case (state_q)
                S_IDLE: begin
                    if (cnt_q < CNT_W'(BUF_DEPTH)) begin
                        state_d = S_WAIT;
                        addr_d  = pc_q;
                        pc_d    = pc_q + 32'd4;
                    end
                end
                S_WAIT: begin
                    if (imem_valid_i) begin
                        state_d = S_IDLE;
                        push    = 1'b1;
                    end
                end
                S_DROP: begin
                    if (imem_valid_i) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
            if (pop)  head_d = head_q + PTR_W'(1);
            if (push) tail_d = tail_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
        req_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    // Each entry keeps the word and its fetch address + 4.
    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_data_q[tail_q] <= imem_data_i;
            buf_addr_q[tail_q] <= addr_q + 32'd4;
        end
    end

    assign imem_req_o   = req_q;
    assign imem_addr_o  = addr_q;
    assign inst_valid_o = !empty;
    assign inst_o       = empty ? BUBBLE : buf_data_q[head_q];
    assign inst_addr_o  = empty ? BUBBLE : buf_addr_q[head_q];

`ifdef IF_FETCH_STATS_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (push)           fetch_cnt_q  <= fetch_cnt_q + 32'd1;
            if (empty && !hd_i) bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign stat_fetch_o  = fetch_cnt_q;
    assign stat_bubble_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: memory responder, queue-based reference model and directed scenarios.
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] BUBBLE = 32'hFC00_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_i = 1'b0, hd_i = 1'b0, redirect_i = 1'b0;
    logic [31:0] redirect_addr_i = '0;
    logic        imem_req_o, imem_valid_i, inst_valid_o;
    logic [31:0] imem_addr_o, imem_data_i, inst_o, inst_addr_o;
`ifdef IF_FETCH_STATS_EN
    logic [31:0] stat_fetch_o, stat_bubble_o;
`endif

    logic        mem_valid = 1'b0, stray_valid = 1'b0;
    logic [31:0] mem_data = '0;
    assign imem_valid_i = mem_valid | stray_valid;
    assign imem_data_i  = mem_valid ? mem_data : 32'hBAD0_BAD0;

    if_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .hd_i(hd_i), .redirect_i(redirect_i),
        .redirect_addr_i(redirect_addr_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_valid_i(imem_valid_i), .imem_data_i(imem_data_i), .inst_o(inst_o),
        .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
`ifdef IF_FETCH_STATS_EN
        , .stat_fetch_o(stat_fetch_o), .stat_bubble_o(stat_bubble_o)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    int checks = 0, failures = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state, updated on posedge from the sampled inputs.
    logic [31:0] mq[$];
    logic        pend = 1'b0, drop = 1'b0, in_rst = 1'b1;
    logic [31:0] pend_addr = '0, exp_pc = RST_PC;
    int          cyc = 0, m_fetch = 0, m_bubble = 0;
    logic [31:0] issue_log[$];
    int          issue_cyc[$];
    logic        arm_fv = 1'b0;
    logic [31:0] fv_addr = '0;
    int          fv_cyc = 0;

    // Memory responder: one request at a time, response lat cycles after the request appears.
    int          lat = 1, mcnt = 0;
    logic        busy = 1'b0;
    logic [31:0] maddr = '0;
    always @(negedge clk) begin
        mem_valid = 1'b0;
        if (in_rst) busy = 1'b0;
        else if (busy) begin
            mcnt++;
            if (mcnt >= lat) begin
                mem_valid = 1'b1;
                mem_data  = mem_word(maddr);
                busy      = 1'b0;
            end
        end else if (imem_req_o) begin
            busy  = 1'b1;
            maddr = imem_addr_o;
            mcnt  = 0;
        end
    end

    always @(posedge clk) begin
        if (!rst_n_i) begin
            mq.delete();
            pend = 1'b0; drop = 1'b0; exp_pc = RST_PC; cyc = 0; in_rst = 1'b1;
            m_fetch = 0; m_bubble = 0;
        end else begin
            in_rst = 1'b0;
            cyc++;
            if (mq.size() == 0 && !hd_i) m_bubble++;
            if (redirect_i) begin
                mq.delete();
                exp_pc = redirect_addr_i & 32'hFFFF_FFFC;
                if (pend && !imem_valid_i) drop = 1'b1;
                else begin pend = 1'b0; drop = 1'b0; end
            end else begin
                if (!hd_i && mq.size() > 0) void'(mq.pop_front());
                if (pend && imem_valid_i) begin
                    if (!drop) begin
                        mq.push_back(pend_addr + 32'd4);
                        m_fetch++;
                    end
                    pend = 1'b0; drop = 1'b0;
                end
            end
        end
    end

    // Compare process: checks every output once per cycle on the falling edge.
    always @(negedge clk) begin
        if (in_rst) begin
            chk("rst_req", 32'(imem_req_o), 0);
            chk("rst_imem_addr", imem_addr_o, RST_PC);
        end
        if (mq.size() == 0) begin
            chk("empty_valid", 32'(inst_valid_o), 0);
            chk("empty_inst", inst_o, BUBBLE);
            chk("empty_addr", inst_addr_o, BUBBLE);
        end else begin
            chk("head_valid", 32'(inst_valid_o), 1);
            chk("head_addr", inst_addr_o, mq[0]);
            chk("head_inst", inst_o, mem_word(mq[0] - 32'd4));
        end
        if (pend) begin
            chk("pend_req", 32'(imem_req_o), 1);
            chk("pend_addr_stable", imem_addr_o, pend_addr);
        end else if (imem_req_o && !in_rst) begin
            chk("issue_addr", imem_addr_o, exp_pc);
            chk("no_overflow", 32'(mq.size() < DEPTH), 1);
            pend = 1'b1; drop = 1'b0; pend_addr = imem_addr_o;
            exp_pc = exp_pc + 32'd4;
            issue_log.push_back(imem_addr_o);
            issue_cyc.push_back(cyc);
        end
        if (arm_fv && inst_valid_o) begin
            fv_addr = inst_addr_o; fv_cyc = cyc; arm_fv = 1'b0;
        end
`ifdef IF_FETCH_STATS_EN
        chk("stat_fetch", stat_fetch_o, 32'(m_fetch));
        chk("stat_bubble", stat_bubble_o, 32'(m_bubble));
`endif
    end

    task automatic redirect_to(input logic [31:0] a);
        redirect_i = 1'b1; redirect_addr_i = a;
        @(posedge clk); #1;
        issue_log.delete(); issue_cyc.delete(); arm_fv = 1'b1;
        @(negedge clk);
        redirect_i = 1'b0;
    endtask

    task automatic wait_fv(input string name);
        for (int i = 0; i < 40 && arm_fv; i++) @(negedge clk);
        chk(name, 32'(arm_fv), 0);
    endtask

    task automatic wait_req_rise(input string name);
        int n = 0;
        while (imem_req_o && n < 40) begin @(negedge clk); n++; end
        while (!imem_req_o && n < 40) begin @(negedge clk); n++; end
        chk(name, 32'(imem_req_o), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("t1_reset_req", 32'(imem_req_o), 0);
        chk("t1_reset_addr", imem_addr_o, 32'h100);
        chk("t1_reset_valid", 32'(inst_valid_o), 0);
        chk("t1_reset_inst", inst_o, 32'hFC00_0000);
        issue_log.delete(); issue_cyc.delete(); arm_fv = 1'b1;
        rst_n_i = 1'b1;
        for (int i = 0; i < 30 && issue_log.size() < 3; i++) @(negedge clk);
        chk("t1_three_issues", 32'(issue_log.size() >= 3), 1);
        if (issue_log.size() >= 3) begin
            chk("t1_addr0", issue_log[0], 32'h100);
            chk("t1_addr1", issue_log[1], 32'h104);
            chk("t1_addr2", issue_log[2], 32'h108);
            chk("t1_cyc0", 32'(issue_cyc[0]), 1);
            chk("t1_cyc1", 32'(issue_cyc[1]), 4);
            chk("t1_cyc2", 32'(issue_cyc[2]), 7);
        end
        chk("t1_fv_addr", fv_addr, 32'h104);
        chk("t1_fv_cyc", 32'(fv_cyc), 3);

        // Stall fills the buffer; request line stays low while full.
        hd_i = 1'b1;
        redirect_to(32'h300);
        repeat (14) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("t2_full_req", 32'(imem_req_o), 0);
            chk("t2_held_addr", inst_addr_o, 32'h304);
            chk("t2_held_inst", inst_o, mem_word(32'h300));
            @(negedge clk);
        end
        hd_i = 1'b0;
        @(negedge clk);
        chk("t2_release_next", inst_addr_o, 32'h308);
        repeat (10) @(negedge clk);

        // Redirect while a slow request is outstanding: late response is dropped.
        lat = 3;
        wait_req_rise("t3_req_rise");
        redirect_to(32'h203);
        chk("t3_bubble_after_redirect", 32'(inst_valid_o), 0);
        wait_fv("t3_fv_seen");
        chk("t3_first_issue", issue_log.size() > 0 ? issue_log[0] : 32'hFFFF_FFFF, 32'h200);
        chk("t3_fv_addr", fv_addr, 32'h204);

        // Full buffer, stray response, redirect and unstalled all at once.
        lat = 1; hd_i = 1'b1;
        redirect_to(32'h600);
        repeat (14) @(negedge clk);
        chk("t4_full_req", 32'(imem_req_o), 0);
        chk("t4_full_head", inst_addr_o, 32'h604);
        stray_valid = 1'b1; hd_i = 1'b0;
        redirect_i = 1'b1; redirect_addr_i = 32'h500;
        @(posedge clk); #1;
        issue_log.delete(); issue_cyc.delete(); arm_fv = 1'b1;
        @(negedge clk);
        stray_valid = 1'b0; redirect_i = 1'b0;
        chk("t4_empty_valid", 32'(inst_valid_o), 0);
        chk("t4_empty_inst", inst_o, 32'hFC00_0000);
        wait_fv("t4_fv_seen");
        chk("t4_first_issue", issue_log.size() > 0 ? issue_log[0] : 32'hFFFF_FFFF, 32'h500);
        chk("t4_fv_addr", fv_addr, 32'h504);

        // PC wrap at the top of the address space.
        redirect_to(32'hFFFF_FFFC);
        wait_fv("t5_fv_seen");
        chk("t5_fv_addr", fv_addr, 32'h0000_0000);
        for (int i = 0; i < 10 && issue_log.size() < 2; i++) @(negedge clk);
        chk("t5_issue0", issue_log.size() > 0 ? issue_log[0] : 32'h1, 32'hFFFF_FFFC);
        chk("t5_issue1", issue_log.size() > 1 ? issue_log[1] : 32'h1, 32'h0000_0000);

        // Reset while waiting abandons the request; fetch restarts at RESET_PC.
        lat = 4;
        wait_req_rise("t6_req_rise");
        rst_n_i = 1'b0;
        @(negedge clk);
        issue_log.delete(); issue_cyc.delete(); arm_fv = 1'b1;
        rst_n_i = 1'b1; lat = 2;
        wait_fv("t6_fv_seen");
        chk("t6_issue0", issue_log.size() > 0 ? issue_log[0] : 32'h1, 32'h100);
        chk("t6_fv_addr", fv_addr, 32'h104);

        // Mixed traffic checked by the model every cycle.
        for (int i = 0; i < 500; i++) begin
            hd_i = ($urandom_range(0, 3) == 0);
            lat = $urandom_range(1, 4);
            stray_valid = (!imem_req_o && $urandom_range(0, 19) == 0);
            redirect_i = ($urandom_range(0, 39) == 0);
            redirect_addr_i = $urandom;
            @(negedge clk);
        end
        hd_i = 1'b0; redirect_i = 1'b0; stray_valid = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, prefetch buffer entries; legal values 2, 4, 8.
REQ-003 SHALL have one clock; reset is synchronous and active-low. Ports: clk_i, rst_n_i.
REQ-004 SHALL have ports:
 - clk_i  in  1  clock, all state updates on posedge
 - rst_n_i  in  1  synchronous active-low reset
 - hd_i  in  1  hazard stall from hazard unit; 1 = downstream holds, no pop
 - redirect_i  in  1  branch/jump taken, discard all fetched state
 - redirect_addr_i  in  32  new fetch address, sampled when redirect_i=1
 - imem_req_o  out  1  instruction memory request outstanding
 - imem_addr_o  out  32  word address of outstanding request
 - imem_valid_i  in  1  response strobe, completes outstanding request
 - imem_data_i  in  32  instruction word, valid with imem_valid_i
 - inst_o  out  32  instruction word to IF/ID register
 - inst_addr_o  out  32  fetch address + 4 of inst_o
 - inst_valid_o  out  1  inst_o holds a real instruction

Function
REQ-005 SHALL keep fetch PC register; each issued request uses PC, then PC += 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-006 SHALL hold at most one outstanding memory request; imem_addr_o stable while imem_req_o=1; response latency >= 1 cycle, unbounded.
REQ-007 SHALL run request FSM states IDLE, WAIT, DROP:
 - IDLE -> WAIT when occupancy + 0 < BUF_DEPTH and no redirect; assert imem_req_o next cycle.
 - WAIT -> IDLE on imem_valid_i; data written to buffer tail.
 - WAIT -> DROP on redirect_i without imem_valid_i same cycle.
 - DROP -> IDLE on imem_valid_i; data discarded, no buffer write.
REQ-008 SHALL issue request only if buffer occupancy plus outstanding count < BUF_DEPTH (no overflow ever).
REQ-009 SHALL present buffer head combinationally on inst_o/inst_addr_o with inst_valid_o=1 when non-empty.
REQ-010 SHALL output inst_o=32'hFC00_0000, inst_addr_o=32'hFC00_0000, inst_valid_o=0 when buffer empty (bubble encoding matches IF/ID flush word).
REQ-011 SHALL pop head on posedge when hd_i=0 and buffer non-empty; hd_i=1 holds inst_o/inst_addr_o unchanged.
REQ-012 SHALL allow push and pop same cycle when full (occupancy unchanged) and when empty is not bypassed (data visible cycle after push).
REQ-013 SHALL on redirect_i=1: clear buffer, load PC = redirect_addr_i, enter DROP if request outstanding and imem_valid_i=0 else IDLE; first new request issued next cycle.
REQ-014 SHALL give redirect_i priority over hd_i, pop and push in same cycle; coincident imem_valid_i response discarded.
REQ-015 SHALL ignore redirect_addr_i low two bits (forced to 0).
REQ-016 SHALL ignore imem_valid_i in IDLE.

Reset
REQ-017 SHALL on rst_n_i=0 at posedge: PC=RESET_PC, FSM=IDLE, buffer empty, imem_req_o=0, imem_addr_o=RESET_PC, inst_o=32'hFC00_0000, inst_addr_o=32'hFC00_0000, inst_valid_o=0.
REQ-018 SHALL treat reset during WAIT as abandoning the request; a response arriving after reset deasserts is ignored by IDLE.

Configuration
REQ-019 SHALL, when macro IF_FETCH_STATS_EN is defined, add outputs stat_fetch_o[31:0] (count of buffer pushes) and stat_bubble_o[31:0] (cycles with inst_valid_o=0 and hd_i=0), both reset to 0, wrapping at 2^32.
REQ-020 SHALL, without IF_FETCH_STATS_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-021 Reset with RESET_PC=0x100, memory latency 1 -> imem_addr_o sequence 0x100,0x104,0x108; first inst_valid_o=1 with inst_addr_o=0x104.
REQ-022 hd_i=1 for 4 cycles with streaming memory -> inst_o held constant, buffer fills to BUF_DEPTH, imem_req_o stays 0 once full; release resumes in order, no loss or duplicate.
REQ-023 redirect_i=1, redirect_addr_i=0x200 while WAIT (latency 3) -> late response discarded, next imem_addr_o=0x200, inst_valid_o=0 until 0x200 word arrives with inst_addr_o=0x204.
REQ-024 redirect_i, imem_valid_i, hd_i=0 all in one cycle with full buffer -> buffer empty next cycle, response not written, PC=redirect target.
REQ-025 PC=0xFFFF_FFFC fetch -> inst_addr_o=0x0000_0000 and next imem_addr_o=0x0000_0000.
REQ-026 With IF_FETCH_STATS_EN, 10 fetched words and 3 empty unstalled cycles -> stat_fetch_o=10, stat_bubble_o=3; rst_n_i=0 clears both.
